core_boot_ctrl: RTL
===================

CORE_BOOT_CTRL -- requirements
Module: core_boot_ctrl

Interface
REQ-001 SHALL provide parameters: IMEM_AW, default 8, instruction-memory byte address width; CYC_W, default 16, run-cycle counter width.
REQ-002 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: load_start  in  1  request to load a program and run it.
REQ-005 SHALL have ports: load_len  in  IMEM_AW+1  program length in bytes, sampled on accepted load_start.
REQ-006 SHALL have ports: run_limit  in  CYC_W  number of core cycles to run, 0 = unlimited, sampled on accepted load_start.
REQ-007 SHALL have ports: abort  in  1  return to IDLE.
REQ-008 SHALL have ports: s_valid  in  1, s_data  in  8, s_ready  out  1  byte-stream input handshake, big-endian byte order.
REQ-009 SHALL have ports: imem_we  out  1, imem_addr  out  IMEM_AW, imem_wdata  out  8  instruction-memory byte write port.
REQ-010 SHALL have ports: core_rst  out  1  processor reset; core_en  out  1  processor advance enable.
REQ-011 SHALL have ports: busy  out  1, done  out  1 (pulse), err  out  1 (pulse), cyc_count  out  CYC_W.

Function
REQ-012 SHALL implement states IDLE, LOAD, RELEASE, RUN, HALT.
REQ-013 In IDLE, load_start with 1 <= load_len <= 2^IMEM_AW SHALL go to LOAD, latch load_len and run_limit, and clear the byte index and cyc_count.
REQ-014 In IDLE or HALT, load_start with load_len == 0 or load_len > 2^IMEM_AW SHALL be ignored and SHALL raise err for one cycle.
REQ-015 load_start SHALL be ignored in LOAD, RELEASE and RUN, with no err.
REQ-016 s_ready SHALL be combinational: 1 only in LOAD and abort == 0.
REQ-017 A byte SHALL be accepted on a cycle where s_valid and s_ready are both 1.
REQ-018 Each accepted byte k (k = 0..len-1) SHALL produce imem_we = 1, imem_addr = k, imem_wdata = s_data on the next cycle, 1-cycle latency.
REQ-019 imem_we SHALL be 0 on all other cycles.
REQ-020 Acceptance of byte len-1 SHALL move LOAD to RELEASE, so no byte beyond len is ever accepted.
REQ-021 s_valid low in LOAD SHALL stall indefinitely with no timeout.
REQ-022 RELEASE SHALL last exactly 1 cycle, keeping core_rst = 1 while the final write lands, then go to RUN.
REQ-023 RUN SHALL drive core_rst = 0 and core_en = 1; cyc_count SHALL increment each RUN cycle and saturate at all-ones.
REQ-024 In RUN with run_limit != 0, the cycle where cyc_count == run_limit-1 SHALL be the last enabled cycle: next state HALT, done = 1 for that next cycle; core_en SHALL be high for exactly run_limit cycles.
REQ-025 With run_limit == 0, RUN SHALL continue until abort or rst.
REQ-026 HALT SHALL drive core_rst = 0 and core_en = 0, preserving core state for inspection.
REQ-027 A valid load_start in HALT SHALL go to LOAD as in IDLE.
REQ-028 core_rst SHALL be 1 in IDLE, LOAD and RELEASE.
REQ-029 busy SHALL be 1 in LOAD, RELEASE and RUN.
REQ-030 abort in LOAD, RELEASE, RUN or HALT SHALL go to IDLE next cycle, take priority over a same-cycle handshake or limit hit, and suppress done.
REQ-031 A write registered from the cycle before an abort SHALL still issue.

Reset
REQ-032 rst SHALL override everything, including mid-LOAD and mid-RUN.
REQ-033 Reset values on the cycle after rst: state IDLE, core_rst = 1, core_en = 0, s_ready = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0, busy = 0, done = 0, err = 0, cyc_count = 0, latched len/limit = 0.

Verification
REQ-034 Load 20 bytes 01 4B 48 20 01 4B 48 22 8D 28 00 04 AD 28 00 08 11 00 00 01, run_limit = 5, s_valid always 1 -> writes to addr 0..19 in order with matching data, s_ready low after the 20th accept, 1 RELEASE cycle with core_rst = 1, core_en high exactly 5 cycles, done pulse, cyc_count = 5.
REQ-035 Same program with s_valid toggling 1/0 each cycle -> identical write sequence, no duplicate or skipped address.
REQ-036 load_len = 0, then load_len = 257 -> err pulse each time, state stays IDLE, no imem_we.
REQ-037 Abort after byte 7 is accepted -> byte 7 write still issues, IDLE next cycle, s_ready 0, no done; a new 4-byte load then writes starting at addr 0.
REQ-038 rst asserted mid-RUN with run_limit = 0 -> all outputs at reset values next cycle.
REQ-039 load_start in RUN -> ignored, no err.
REQ-040 load_start in HALT with load_len = 4 -> reloads addr 0..3 and reruns.

Source files
------------

// File: rtl/core_boot_ctrl_if.sv
// Boot controller bus bundle: the program byte stream coming in and the
// instruction-memory byte write port going out.
interface core_boot_ctrl_if #(
  parameter int unsigned IMEM_AW = 8
);
  logic               s_valid;
  logic [7:0]         s_data;
  logic               s_ready;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [7:0]         imem_wdata;

  // master: byte source and memory sink (testbench / SoC side)
  modport master (
    output s_valid, s_data,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );

  // slave: the boot controller itself
  modport slave (
    input  s_valid, s_data,
    output s_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/core_boot_ctrl.sv
// Boot controller: streams a program into instruction memory while the core
// is held in reset, releases the core, runs it for a bounded (or unbounded)
// number of cycles, then halts it with its state preserved for inspection.
module core_boot_ctrl #(
  parameter int unsigned IMEM_AW = 8,
  parameter int unsigned CYC_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic [IMEM_AW:0] load_len,
  input  logic [CYC_W-1:0] run_limit,
  input  logic             abort,
  core_boot_ctrl_if.slave  bus,
  output logic             core_rst,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CYC_W-1:0] cyc_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_HALT
  } state_t;

  localparam logic [IMEM_AW:0]   LEN_MAX = {1'b1, {IMEM_AW{1'b0}}};
  localparam logic [IMEM_AW:0]   LEN_ONE = {{IMEM_AW{1'b0}}, 1'b1};
  localparam logic [IMEM_AW-1:0] IDX_ONE = {{(IMEM_AW-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0]   CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_next;
  logic [IMEM_AW:0]   r_len;
  logic [CYC_W-1:0]   r_limit;
  logic [CYC_W-1:0]   r_cyc;
  logic [IMEM_AW-1:0] r_idx;
  logic [IMEM_AW-1:0] r_addr;
  logic [7:0]         r_wdata;
  logic               r_we;
  logic               r_done;
  logic               r_err;

  logic w_len_ok;
  logic w_can_start;
  logic w_start;
  logic w_bad_start;
  logic w_accept;
  logic w_last_byte;
  logic w_limit_hit;

  // Decode handshakes, load requests and terminal conditions from current state
  always_comb begin
    w_len_ok    = (load_len != '0) && (load_len <= LEN_MAX);
    // abort in HALT wins over a new load request
    w_can_start = (r_state == S_IDLE) || ((r_state == S_HALT) && !abort);
    w_start     = w_can_start && load_start && w_len_ok;
    w_bad_start = w_can_start && load_start && !w_len_ok;
    w_accept    = (r_state == S_LOAD) && !abort && bus.s_valid;
    w_last_byte = ({1'b0, r_idx} == (r_len - LEN_ONE));
    w_limit_hit = (r_limit != '0) && (r_cyc == (r_limit - CYC_ONE));
  end

  // Next-state selection; abort has priority over handshake and limit hit
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_next = S_LOAD;
      S_LOAD:    if (abort) w_next = S_IDLE;
                 else if (w_accept && w_last_byte) w_next = S_RELEASE;
      S_RELEASE: w_next = abort ? S_IDLE : S_RUN;
      S_RUN:     if (abort) w_next = S_IDLE;
                 else if (w_limit_hit) w_next = S_HALT;
      S_HALT:    if (abort) w_next = S_IDLE;
                 else if (w_start) w_next = S_LOAD;
      default:   w_next = S_IDLE;
    endcase
  end

  // Output decode: state-derived controls plus registered write/pulse outputs
  always_comb begin
    bus.s_ready    = (r_state == S_LOAD) && !abort;
    bus.imem_we    = r_we;
    bus.imem_addr  = r_addr;
    bus.imem_wdata = r_wdata;
    core_rst       = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_RELEASE);
    core_en        = (r_state == S_RUN);
    busy           = (r_state == S_LOAD) || (r_state == S_RELEASE) || (r_state == S_RUN);
    done           = r_done;
    err            = r_err;
    cyc_count      = r_cyc;
  end

  // State register, byte-write pipeline, run counter and latched load parameters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_limit <= '0;
      r_cyc   <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_we    <= w_accept;
      r_done  <= (r_state == S_RUN) && !abort && w_limit_hit;
      r_err   <= w_bad_start;
      if (w_accept) begin
        r_addr  <= r_idx;
        r_wdata <= bus.s_data;
        r_idx   <= r_idx + IDX_ONE;
      end
      if (w_start) begin
        r_len   <= load_len;
        r_limit <= run_limit;
        r_idx   <= '0;
        r_cyc   <= '0;
      end else if ((r_state == S_RUN) && (r_cyc != '1)) begin
        r_cyc <= r_cyc + CYC_ONE;
      end
    end
  end

endmodule
